// File: rtl/ann_seq_classifier.sv
// Sequential two-layer fixed-point MLP classifier with one shared MAC and a run-time writable
// parameter RAM; valid/ready on input and output, argmax class plus winning score out.
module ann_seq_classifier #(
  parameter int N_IN  = 8,
  parameter int N_HID = 16,
  parameter int N_CLS = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40,
  localparam int W_DEPTH = N_HID * N_IN + N_HID + N_CLS * N_HID + N_CLS
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [N_IN*DW-1:0]                           in_data,
  input  logic                                         wr_en,
  input  logic [$clog2(W_DEPTH)-1:0]                   wr_addr,
  input  logic signed [DW-1:0]                         wr_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [((N_CLS > 2) ? $clog2(N_CLS) : 1)-1:0] out_class,
  output logic signed [DW-1:0]                         out_score,
  output logic                                         busy
);

  localparam int AW     = $clog2(W_DEPTH);
  localparam int CW     = (N_CLS > 2) ? $clog2(N_CLS) : 1;
  localparam int KMAX   = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KW     = $clog2(KMAX + 1);
  localparam int NMAX   = (N_HID > N_CLS) ? N_HID : N_CLS;
  localparam int NW     = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int XW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OFF_B1 = N_HID * N_IN;
  localparam int OFF_W2 = OFF_B1 + N_HID;
  localparam int OFF_B2 = OFF_W2 + N_CLS * N_HID;

  localparam logic [KW-1:0] K_L1      = KW'(N_IN);
  localparam logic [KW-1:0] K_L2      = KW'(N_HID);
  localparam logic [NW-1:0] N_L1_LAST = NW'(N_HID - 1);
  localparam logic [NW-1:0] N_L2_LAST = NW'(N_CLS - 1);

  typedef enum logic [1:0] {StIdle, StL1, StL2, StDone} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [NW-1:0]            n_q, n_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]     best_q, best_d;
  logic [CW-1:0]            cls_q, cls_d;

  logic signed [DW-1:0]     ram [W_DEPTH];
  logic signed [DW-1:0]     x_q [N_IN];
  logic signed [DW-1:0]     a_q [N_HID];

  logic [AW-1:0]            rd_addr;
  logic signed [DW-1:0]     w;
  logic signed [DW-1:0]     operand;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  b_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  t;
  logic                     fits;
  logic signed [DW-1:0]     fin;
  logic                     x_we;
  logic                     a_we;

  // Shared datapath: one RAM word and one operand per cycle feed either a MAC or a finalise.
  always_comb begin
    rd_addr = '0;
    operand = '0;
    if (state_q == StL1) begin
      operand = x_q[k_q[XW-1:0]];
      if (k_q == K_L1) rd_addr = AW'(OFF_B1) + AW'(n_q);
      else             rd_addr = AW'(n_q) * AW'(N_IN) + AW'(k_q);
    end else if (state_q == StL2) begin
      operand = a_q[k_q[HW-1:0]];
      if (k_q == K_L2) rd_addr = AW'(OFF_B2) + AW'(n_q);
      else             rd_addr = AW'(OFF_W2) + AW'(n_q) * AW'(N_HID) + AW'(k_q);
    end
    w        = ram[rd_addr];
    prod     = operand * w;
    prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
    b_ext    = {{(ACC_W - DW){w[DW-1]}}, w};
    sum      = acc_q + (b_ext <<< FRAC);
    t        = sum >>> FRAC;
    if (state_q == StL1 && t[ACC_W-1]) t = '0;
    // In range iff all bits from the DW sign bit upward agree.
    fits = (&t[ACC_W-1:DW-1]) | ~(|t[ACC_W-1:DW-1]);
    if (fits)            fin = t[DW-1:0];
    else if (t[ACC_W-1]) fin = {1'b1, {(DW - 1){1'b0}}};
    else                 fin = {1'b0, {(DW - 1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    acc_d   = acc_q;
    best_d  = best_q;
    cls_d   = cls_q;
    x_we    = 1'b0;
    a_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_we    = 1'b1;
          k_d     = '0;
          n_d     = '0;
          acc_d   = '0;
          state_d = StL1;
        end
      end
      StL1: begin
        if (k_q == K_L1) begin
          a_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (n_q == N_L1_LAST) begin
            n_d     = '0;
            state_d = StL2;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          acc_d = acc_q + prod_ext;
          k_d   = k_q + 1'b1;
        end
      end
      StL2: begin
        if (k_q == K_L2) begin
          acc_d = '0;
          k_d   = '0;
          // Strict compare keeps the lowest index on ties.
          if (n_q == '0 || fin > best_q) begin
            best_d = fin;
            cls_d  = CW'(n_q);
          end
          if (n_q == N_L2_LAST) begin
            n_d     = '0;
            state_d = StDone;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          acc_d = acc_q + prod_ext;
          k_d   = k_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      best_q  <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      cls_q   <= cls_d;
    end
  end

  // Storage outside the reset domain: RAM survives reset, scratch arrays are simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == StIdle && {1'b0, wr_addr} < (AW + 1)'(W_DEPTH)) begin
      ram[wr_addr] <= wr_data;
    end
    if (x_we) begin
      for (int i = 0; i < N_IN; i++) x_q[i] <= in_data[i*DW +: DW];
    end
    if (a_we) a_q[n_q[HW-1:0]] <= fin;
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = cls_q;
  assign out_score = best_q;

endmodule

// File: tb/tb_ann_seq_classifier.sv
// Bench for ann_seq_classifier: directed scenarios plus randomized weights/features checked
// against an integer-arithmetic reference of the two-layer MLP.
module tb_ann_seq_classifier;

  localparam int N_IN    = 8;
  localparam int N_HID   = 16;
  localparam int N_CLS   = 4;
  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int W_DEPTH = N_HID * N_IN + N_HID + N_CLS * N_HID + N_CLS;
  localparam int AW      = $clog2(W_DEPTH);
  localparam int OFF_B1  = N_HID * N_IN;
  localparam int OFF_W2  = OFF_B1 + N_HID;
  localparam int OFF_B2  = OFF_W2 + N_CLS * N_HID;
  localparam int LAT     = N_HID * (N_IN + 1) + N_CLS * (N_HID + 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_class;
  logic signed [DW-1:0] out_score;
  logic                 busy;

  ann_seq_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_t[$];
  int w[W_DEPTH];
  int feat[N_IN];

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_t.push_back(cyc);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap40(input longint v);
    return (v <<< 24) >>> 24;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: plain integer evaluation of ReLU hidden layer, linear output layer, argmax.
  function automatic void model(output int cls, output int score);
    int     a[N_HID];
    longint acc;
    longint t;
    int     s;
    cls = 0;
    score = 0;
    for (int h = 0; h < N_HID; h++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc = wrap40(acc + longint'(feat[i]) * longint'(w[h*N_IN+i]));
      t = wrap40(acc + (longint'(w[OFF_B1+h]) <<< FRAC)) >>> FRAC;
      if (t < 0) t = 0;
      a[h] = sat16(t);
    end
    for (int c = 0; c < N_CLS; c++) begin
      acc = 0;
      for (int h = 0; h < N_HID; h++)
        acc = wrap40(acc + longint'(a[h]) * longint'(w[OFF_W2+c*N_HID+h]));
      t = wrap40(acc + (longint'(w[OFF_B2+c]) <<< FRAC)) >>> FRAC;
      s = sat16(t);
      if (c == 0 || s > score) begin
        score = s;
        cls = c;
      end
    end
  endfunction

  function automatic logic [N_IN*DW-1:0] pack();
    logic [N_IN*DW-1:0] d;
    for (int i = 0; i < N_IN; i++) d[i*DW +: DW] = feat[i][DW-1:0];
    return d;
  endfunction

  task automatic wr(input int a, input int v);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = v[DW-1:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int a = 0; a < W_DEPTH; a++) wr(a, w[a]);
  endtask

  task automatic clear_w();
    for (int a = 0; a < W_DEPTH; a++) w[a] = 0;
  endtask

  task automatic rand_w(input int span);
    for (int a = 0; a < W_DEPTH; a++) w[a] = int'($urandom_range(0, 2 * span - 1)) - span;
  endtask

  task automatic rand_feat();
    for (int i = 0; i < N_IN; i++) feat[i] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  // One inference from a negedge: optional write while busy, optional output stall.
  task automatic infer(input string tag, input int hold, input bit busy_wr);
    int ec, es, n;
    model(ec, es);
    check({tag, ".in_ready"}, in_ready, 1);
    in_data  = pack();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;  // the accepting edge is the first of LAT
    if (busy_wr) begin
      wr(OFF_B2 + 3, 32767);
      n++;
    end
    while (!out_valid && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, LAT);
    check({tag, ".class"}, out_class, ec);
    check({tag, ".score"}, out_score, es);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i % 10 == 9) begin
        check({tag, ".stall_valid"}, out_valid, 1);
        check({tag, ".stall_ready"}, in_ready, 0);
        check({tag, ".stall_class"}, out_class, ec);
        check({tag, ".stall_score"}, out_score, es);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_ready"}, in_ready, 1);
  endtask

  initial begin
    int c1, s1, c2, s2, n;
    logic [N_IN*DW-1:0] d2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_class", out_class, 0);
    check("rst.out_score", out_score, 0);
    check("rst.busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel.in_ready", in_ready, 1);

    rand_w(512);
    load_all();
    for (int k = 0; k < 3; k++) begin
      rand_feat();
      infer("rand", 0, 1'b0);
    end

    // Abort mid-L1; RAM must survive.
    rand_feat();
    in_data  = pack();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst.in_ready", in_ready, 0);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.out_class", out_class, 0);
    check("midrst.out_score", out_score, 0);
    check("midrst.busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.rel_ready", in_ready, 1);
    repeat (20) @(negedge clk);
    check("midrst.no_valid", out_valid, 0);
    infer("after_rst", 0, 1'b0);

    clear_w();
    w[OFF_B2+2] = 256;
    load_all();
    rand_feat();
    infer("bias", 0, 1'b0);

    clear_w();
    w[0*N_IN+7] = 256;
    w[OFF_W2+1*N_HID+0] = 256;
    load_all();
    for (int i = 0; i < N_IN; i++) feat[i] = 0;
    feat[7] = 42;
    infer("path_pos", 0, 1'b0);
    feat[7] = -42;
    infer("path_neg", 0, 1'b0);

    // Write while busy is dropped (model untouched); same write in IDLE flips the winner.
    feat[7] = 42;
    infer("stall_gate", 50, 1'b1);
    w[OFF_B2+3] = 32767;
    wr(OFF_B2 + 3, 32767);
    infer("idle_write", 0, 1'b0);

    clear_w();
    for (int a = 0; a < OFF_B1; a++) w[a] = 32767;
    for (int a = OFF_W2; a < OFF_B2; a++) w[a] = 32767;
    load_all();
    for (int i = 0; i < N_IN; i++) feat[i] = 32767;
    infer("sat", 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    rand_w(512);
    load_all();
    rand_feat();
    model(c1, s1);
    in_data = pack();
    rand_feat();
    model(c2, s2);
    d2 = pack();
    acc_t.delete();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = d2;
    n = 0;
    while (!out_valid && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b.class0", out_class, c1);
    check("b2b.score0", out_score, s1);
    n = 0;
    while (acc_t.size() < 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("b2b.accepts", acc_t.size(), 2);
    n = 0;
    while (!out_valid && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b.class1", out_class, c2);
    check("b2b.score1", out_score, s2);
    if (acc_t.size() >= 2) check("b2b.spacing", acc_t[1] - acc_t[0], LAT + 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b.idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
